// File: rtl/video_sync_sequencer_if.sv
// Control, stream-monitor and status bundle between the video_clk-domain
// sequencer and its environment (VTC, AXIS bridge, PS register slice).
interface video_sync_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 enable;
  logic                 clear_counters;
  logic                 mmcm_locked;
  logic                 vtc_fsync;
  logic                 vtc_active_video;
  logic                 s_axis_tvalid;
  logic                 s_axis_tuser;
  logic                 vtc_en;
  logic                 bridge_resetn;
  logic                 sync_locked;
  logic [2:0]           state_o;
  logic                 irq;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [CNT_WIDTH-1:0] underflow_frames;
  logic [CNT_WIDTH-1:0] restart_count;

  // Environment side: drives control and stream observation, reads status
  modport master (
    output enable, clear_counters, mmcm_locked, vtc_fsync, vtc_active_video,
           s_axis_tvalid, s_axis_tuser,
    input  vtc_en, bridge_resetn, sync_locked, state_o, irq,
           frame_count, underflow_frames, restart_count
  );

  // Sequencer side
  modport slave (
    input  enable, clear_counters, mmcm_locked, vtc_fsync, vtc_active_video,
           s_axis_tvalid, s_axis_tuser,
    output vtc_en, bridge_resetn, sync_locked, state_o, irq,
           frame_count, underflow_frames, restart_count
  );
endinterface

// File: rtl/video_sync_sequencer.sv
// HDMI output-path bring-up and supervision: waits for pixel-clock lock,
// starts the VTC, releases the AXIS-to-video bridge on a stream SOF, then
// watches for underflow / lock loss and forces a bridge re-sync.
module video_sync_sequencer #(
  parameter int unsigned LOCK_SETTLE    = 1024,
  parameter int unsigned VTC_WARMUP     = 2,
  parameter int unsigned SOF_TIMEOUT    = 4,
  parameter int unsigned MAX_BAD_FRAMES = 3,
  parameter int unsigned RECOVER_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                 video_clk,
  input  logic                 resetn,
  video_sync_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CLK  = 3'd1,
    S_START_VTC = 3'd2,
    S_WAIT_SOF  = 3'd3,
    S_RUN       = 3'd4,
    S_RECOVER   = 3'd5
  } state_t;

  // One per-state counter serves settle, warm-up, timeout, bad-frame and recover counts
  localparam int unsigned MAX_A = (LOCK_SETTLE > RECOVER_CYCLES) ? LOCK_SETTLE : RECOVER_CYCLES;
  localparam int unsigned MAX_B = (VTC_WARMUP > SOF_TIMEOUT) ? VTC_WARMUP : SOF_TIMEOUT;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_N = (MAX_C > MAX_BAD_FRAMES) ? MAX_C : MAX_BAD_FRAMES;
  localparam int unsigned PW    = $clog2(MAX_N + 1);

  state_t               r_state, w_next;
  logic [PW-1:0]        r_cnt, w_cnt_nxt;
  logic                 r_sof_seen, w_sof_nxt;
  logic                 r_uf_flag, w_uf_nxt;
  logic                 r_fsync_d1;
  logic                 r_vtc_en, r_bridge_resetn, r_sync_locked, r_irq;
  logic                 w_vtc_en_nxt, w_bridge_resetn_nxt, w_sync_locked_nxt, w_irq_nxt;
  logic                 w_fs_rise, w_uf, w_entry, w_lock_lost;
  logic                 w_frame_inc, w_uf_inc, w_restart_inc;
  logic [CNT_WIDTH-1:0] r_frame_count, r_underflow_frames, r_restart_count;

  assign w_fs_rise = bus.vtc_fsync & ~r_fsync_d1;
  assign w_uf      = bus.vtc_active_video & ~bus.s_axis_tvalid;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // State, per-state bookkeeping and registered outputs
  always_ff @(posedge video_clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_sof_seen      <= 1'b0;
      r_uf_flag       <= 1'b0;
      r_fsync_d1      <= 1'b0;
      r_vtc_en        <= 1'b0;
      r_bridge_resetn <= 1'b0;
      r_sync_locked   <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_cnt           <= w_cnt_nxt;
      r_sof_seen      <= w_sof_nxt;
      r_uf_flag       <= w_uf_nxt;
      r_fsync_d1      <= bus.vtc_fsync;
      r_vtc_en        <= w_vtc_en_nxt;
      r_bridge_resetn <= w_bridge_resetn_nxt;
      r_sync_locked   <= w_sync_locked_nxt;
      r_irq           <= w_irq_nxt;
    end
  end

  // Next state, per-state updates and next-cycle output values
  always_comb begin
    w_next              = r_state;
    w_cnt_nxt           = r_cnt;
    w_sof_nxt           = r_sof_seen;
    w_uf_nxt            = r_uf_flag;
    w_frame_inc         = 1'b0;
    w_uf_inc            = 1'b0;
    w_vtc_en_nxt        = 1'b0;
    w_bridge_resetn_nxt = 1'b0;
    w_sync_locked_nxt   = 1'b0;
    w_lock_lost         = !bus.mmcm_locked &&
                          ((r_state == S_START_VTC) || (r_state == S_WAIT_SOF) || (r_state == S_RUN));

    if (!bus.enable) begin
      w_next = S_IDLE;
    end else if (w_lock_lost) begin
      w_next = S_RECOVER;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_WAIT_CLK;
        S_WAIT_CLK: begin
          if (!bus.mmcm_locked)                    w_cnt_nxt = '0;
          else if (r_cnt == PW'(LOCK_SETTLE - 1))  w_next    = S_START_VTC;
          else                                     w_cnt_nxt = r_cnt + PW'(1);
        end
        S_START_VTC: begin
          if (w_fs_rise) begin
            if (r_cnt == PW'(VTC_WARMUP - 1)) w_next    = S_WAIT_SOF;
            else                              w_cnt_nxt = r_cnt + PW'(1);
          end
        end
        S_WAIT_SOF: begin
          if (bus.s_axis_tvalid && bus.s_axis_tuser) w_sof_nxt = 1'b1;
          if (w_fs_rise) begin
            if (r_sof_seen)                         w_next    = S_RUN;
            else if (r_cnt == PW'(SOF_TIMEOUT - 1)) w_next    = S_RECOVER;
            else                                    w_cnt_nxt = r_cnt + PW'(1);
          end
        end
        S_RUN: begin
          // An underflow on the fsync cycle belongs to the frame that starts there
          if (w_uf) w_uf_nxt = 1'b1;
          if (w_fs_rise) begin
            w_frame_inc = 1'b1;
            w_uf_nxt    = w_uf;
            if (r_uf_flag) begin
              w_uf_inc = 1'b1;
              if (r_cnt == PW'(MAX_BAD_FRAMES - 1)) w_next    = S_RECOVER;
              else                                  w_cnt_nxt = r_cnt + PW'(1);
            end else begin
              w_cnt_nxt = '0;
            end
          end
        end
        S_RECOVER: begin
          if (r_cnt == PW'(RECOVER_CYCLES - 1)) w_next    = S_WAIT_CLK;
          else                                  w_cnt_nxt = r_cnt + PW'(1);
        end
        default: w_next = S_IDLE;
      endcase
    end

    w_entry = (w_next != r_state);
    if (w_entry) begin
      w_cnt_nxt = '0;
      w_sof_nxt = 1'b0;
      w_uf_nxt  = 1'b0;
    end

    case (w_next)
      S_START_VTC: w_vtc_en_nxt = 1'b1;
      S_WAIT_SOF: begin
        w_vtc_en_nxt        = 1'b1;
        w_bridge_resetn_nxt = 1'b1;
      end
      S_RUN: begin
        w_vtc_en_nxt        = 1'b1;
        w_bridge_resetn_nxt = 1'b1;
        w_sync_locked_nxt   = 1'b1;
      end
      S_RECOVER: w_vtc_en_nxt = 1'b1;
      default: ;
    endcase

    w_irq_nxt     = w_entry && ((w_next == S_RUN) || (w_next == S_RECOVER));
    w_restart_inc = w_entry && (w_next == S_RECOVER);
  end

  // Saturating status counters; clear has priority over increment
  always_ff @(posedge video_clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_count      <= '0;
      r_underflow_frames <= '0;
      r_restart_count    <= '0;
    end else if (bus.clear_counters) begin
      r_frame_count      <= '0;
      r_underflow_frames <= '0;
      r_restart_count    <= '0;
    end else begin
      r_frame_count      <= sat_inc(r_frame_count, w_frame_inc);
      r_underflow_frames <= sat_inc(r_underflow_frames, w_uf_inc);
      r_restart_count    <= sat_inc(r_restart_count, w_restart_inc);
    end
  end

  assign bus.vtc_en           = r_vtc_en;
  assign bus.bridge_resetn    = r_bridge_resetn;
  assign bus.sync_locked      = r_sync_locked;
  assign bus.state_o          = r_state;
  assign bus.irq              = r_irq;
  assign bus.frame_count      = r_frame_count;
  assign bus.underflow_frames = r_underflow_frames;
  assign bus.restart_count    = r_restart_count;

endmodule

// File: tb/tb_video_sync_sequencer.sv
// Scoreboard bench for video_sync_sequencer: stimulus queues expected state
// transitions (with arrival cycle) and counter snapshots; a monitor checks them.
module tb_video_sync_sequencer;

  localparam int unsigned CW = 4;

  typedef struct {
    int st;
    int irq;
    int at;
  } trans_t;

  typedef struct {
    int st;
    int fc;
    int uf;
    int rs;
  } snap_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   at_dummy;
  int   rc;
  int   w;

  trans_t tq[$];
  snap_t  sq[$];

  video_sync_sequencer_if #(.CNT_WIDTH(CW)) vif ();

  video_sync_sequencer #(
    .LOCK_SETTLE(8),
    .VTC_WARMUP(2),
    .SOF_TIMEOUT(4),
    .MAX_BAD_FRAMES(3),
    .RECOVER_CYCLES(64),
    .CNT_WIDTH(CW)
  ) dut (
    .video_clk(clk),
    .resetn(resetn),
    .bus(vif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_vtc(input int st);
    return (st >= 2 && st <= 5) ? 1 : 0;
  endfunction
  function automatic int exp_br(input int st);
    return (st == 3 || st == 4) ? 1 : 0;
  endfunction
  function automatic int exp_lk(input int st);
    return (st == 4) ? 1 : 0;
  endfunction

  task automatic exp_t(input int st, input int irq, input int at);
    trans_t e;
    e.st = st; e.irq = irq; e.at = at;
    tq.push_back(e);
  endtask

  task automatic exp_s(input int st, input int fc, input int uf, input int rs);
    snap_t s;
    s.st = st; s.fc = fc; s.uf = uf; s.rs = rs;
    sq.push_back(s);
  endtask

  // Monitor: checks every state change against the queue, irq width, snapshots
  initial begin : monitor
    int st, irq, last_st, last_irq;
    trans_t e;
    snap_t s;
    last_st = 0;
    last_irq = 0;
    forever begin
      @(negedge clk);
      st  = int'(vif.state_o);
      irq = int'(vif.irq);
      if (st != last_st) begin
        if (tq.size() == 0) begin
          chk("unexpected_state_change", st, last_st);
        end else begin
          e = tq.pop_front();
          chk("trans_state", st, e.st);
          chk("trans_vtc_en", int'(vif.vtc_en), exp_vtc(e.st));
          chk("trans_bridge_resetn", int'(vif.bridge_resetn), exp_br(e.st));
          chk("trans_sync_locked", int'(vif.sync_locked), exp_lk(e.st));
          chk("trans_irq", irq, e.irq);
          chk("trans_cycle", cyc, e.at);
        end
        last_st = st;
      end
      if (last_irq != 0) chk("irq_pulse_width", irq, 0);
      last_irq = irq;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("snap_state", st, s.st);
        chk("snap_vtc_en", int'(vif.vtc_en), exp_vtc(s.st));
        chk("snap_bridge_resetn", int'(vif.bridge_resetn), exp_br(s.st));
        chk("snap_sync_locked", int'(vif.sync_locked), exp_lk(s.st));
        chk("snap_frame_count", int'(vif.frame_count), s.fc);
        chk("snap_underflow_frames", int'(vif.underflow_frames), s.uf);
        chk("snap_restart_count", int'(vif.restart_count), s.rs);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // One 16-cycle frame: fsync on cycle 0, active video cycles 4..11,
  // optional underflow on cycle 6, optional SOF on cycle 3, optional clear on the fsync
  task automatic frame(input int exp_st, input int exp_irq, input bit uf, input bit sof,
                       input bit clr, output int at);
    at = -1;
    @(negedge clk);
    vif.vtc_fsync = 1'b1;
    vif.clear_counters = clr;
    if (exp_st >= 0) begin
      at = cyc + 1;
      exp_t(exp_st, exp_irq, at);
    end
    @(negedge clk);
    vif.vtc_fsync = 1'b0;
    vif.clear_counters = 1'b0;
    for (int i = 2; i < 16; i++) begin
      @(negedge clk);
      vif.vtc_active_video = (i >= 4 && i < 12);
      vif.s_axis_tvalid    = !(uf && i == 6);
      vif.s_axis_tuser     = sof && (i == 3);
    end
  endtask

  task automatic power_up();
    @(negedge clk);
    vif.enable = 1'b1;
    vif.mmcm_locked = 1'b1;
    exp_t(1, 0, cyc + 1);
    exp_t(2, 0, cyc + 9);
    repeat (9) @(negedge clk);
  endtask

  // From fresh START_VTC: two warm-up fsyncs, SOF, then RUN on the third
  task automatic bring_up();
    int a;
    frame(-1, 0, 1'b0, 1'b0, 1'b0, a);
    frame(3, 0, 1'b0, 1'b1, 1'b0, a);
    frame(4, 1, 1'b0, 1'b0, 1'b0, a);
  endtask

  initial begin : stimulus
    vif.enable = 1'b0;
    vif.clear_counters = 1'b0;
    vif.mmcm_locked = 1'b0;
    vif.vtc_fsync = 1'b0;
    vif.vtc_active_video = 1'b0;
    vif.s_axis_tvalid = 1'b1;
    vif.s_axis_tuser = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    exp_s(0, 0, 0, 0);

    // Bring-up: state 0,1,2,3,4 with settle of 8 cycles
    power_up();
    bring_up();
    exp_s(4, 0, 0, 0);

    // Underflow: uf, clean, uf, uf, uf -> recovery on the 3rd consecutive bad fsync
    frame(-1, 0, 1'b1, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b1, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b1, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b1, 1'b0, 1'b0, at_dummy);
    exp_s(4, 5, 3, 0);
    frame(5, 1, 1'b0, 1'b0, 1'b0, rc);
    exp_s(5, 6, 4, 1);

    // Recover lasts 64 cycles; lock glitch at settle count 5 restarts settle
    w = rc + 64;
    exp_t(1, 0, w);
    exp_t(2, 0, w + 14);
    wait_cyc(w + 5);
    vif.mmcm_locked = 1'b0;
    @(negedge clk);
    vif.mmcm_locked = 1'b1;
    wait_cyc(w + 14);

    // SOF timeout: no tuser, RECOVER on 4th fsync in WAIT_SOF
    frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    frame(3, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    frame(5, 1, 1'b0, 1'b0, 1'b0, rc);
    exp_s(5, 6, 4, 2);
    exp_t(1, 0, rc + 64);
    exp_t(2, 0, rc + 72);
    wait_cyc(rc + 72);

    // MMCM loss in RUN, then enable drop in RECOVER
    bring_up();
    @(negedge clk);
    vif.mmcm_locked = 1'b0;
    exp_t(5, 1, cyc + 1);
    repeat (3) @(negedge clk);
    exp_s(5, 6, 4, 3);
    @(negedge clk);
    vif.enable = 1'b0;
    exp_t(0, 0, cyc + 1);
    @(negedge clk);
    vif.mmcm_locked = 1'b1;
    repeat (2) @(negedge clk);

    // Saturation at 15 and clear coinciding with fsync
    power_up();
    bring_up();
    for (int i = 0; i < 20; i++) frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    exp_s(4, 15, 4, 3);
    frame(-1, 0, 1'b0, 1'b0, 1'b1, at_dummy);
    exp_s(4, 0, 0, 0);
    frame(-1, 0, 1'b0, 1'b0, 1'b0, at_dummy);
    exp_s(4, 1, 0, 0);

    // Async reset mid-frame
    @(negedge clk);
    vif.vtc_active_video = 1'b1;
    vif.enable = 1'b0;
    exp_t(0, 0, cyc + 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_state", int'(vif.state_o), 0);
    chk("async_reset_vtc_en", int'(vif.vtc_en), 0);
    chk("async_reset_bridge_resetn", int'(vif.bridge_resetn), 0);
    chk("async_reset_sync_locked", int'(vif.sync_locked), 0);
    chk("async_reset_frame_count", int'(vif.frame_count), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    vif.vtc_active_video = 1'b0;

    for (int i = 0; i < 20 && (tq.size() > 0 || sq.size() > 0); i++) @(negedge clk);
    chk("pending_transitions", tq.size(), 0);
    chk("pending_snapshots", sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_sync_sequencer.md
Name: video_sync_sequencer

Overview:
Bring-up and supervision controller for the HDMI output path. It sequences pixel-clock lock, VTC enable and release of the AXIS-to-video bridge reset, then monitors the stream for underflow during active video. It forces a bridge re-sync when the stream stalls or the MMCM drops lock. It sits in the video_clk domain beside the bridge and the VTC, and exposes status and counters to a PS-readable register slice.

Parameters:
LOCK_SETTLE, 1024, consecutive video_clk cycles mmcm_locked must stay high before VTC start (>=1)
VTC_WARMUP, 2, VTC fsync rising edges counted before the bridge is released (>=1)
SOF_TIMEOUT, 4, fsync rising edges allowed in WAIT_SOF without a stream SOF (>=1)
MAX_BAD_FRAMES, 3, consecutive underflowed frames that trigger recovery (>=1)
RECOVER_CYCLES, 64, cycles bridge_resetn is held low in RECOVER (>=1)
CNT_WIDTH, 16, width of all status counters

Ports:
video_clk  in  1  pixel clock, 74.25 MHz
resetn  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run the video path
clear_counters  in  1  1-cycle pulse; zeroes all status counters
mmcm_locked  in  1  pixel MMCM lock, already synchronised to video_clk
vtc_fsync  in  1  VTC frame sync
vtc_active_video  in  1  VTC active video, undelayed
s_axis_tvalid  in  1  bridge input stream valid (monitor only)
s_axis_tuser  in  1  bridge input stream SOF (monitor only)
vtc_en  out  1  VTC generator enable
bridge_resetn  out  1  active-low reset to the bridge
sync_locked  out  1  1 only in RUN
state_o  out  3  current state encoding
irq  out  1  1-cycle pulse on entry to RUN or RECOVER
frame_count  out  CNT_WIDTH  frames completed in RUN
underflow_frames  out  CNT_WIDTH  frames with at least one underflow
restart_count  out  CNT_WIDTH  entries into RECOVER

Behaviour:
- Async reset:
  - state IDLE; all outputs 0; bridge_resetn 0; all counters and internal registers 0.
- fsync edge detect:
  - fs_rise = vtc_fsync & ~fsync_d1, with fsync_d1 a single register.
- State encodings: IDLE=0, WAIT_CLK=1, START_VTC=2, WAIT_SOF=3, RUN=4, RECOVER=5. Others go to IDLE next cycle.
- All outputs are registered; output values track the current state.
- Priority each cycle:
  - enable==0 -> IDLE, from any state.
  - Otherwise, mmcm_locked==0 in START_VTC, WAIT_SOF or RUN -> RECOVER.
  - Otherwise, the per-state rules below apply.
- IDLE:
  - vtc_en=0, bridge_resetn=0.
  - enable=1 -> WAIT_CLK.
- WAIT_CLK:
  - vtc_en=0, bridge_resetn=0.
  - A settle counter increments while mmcm_locked=1 and clears to 0 when it is 0.
  - Settle counter reaching LOCK_SETTLE-1 with lock high -> START_VTC.
- START_VTC:
  - vtc_en=1, bridge_resetn=0.
  - Count fs_rise; the VTC_WARMUP-th edge -> WAIT_SOF.
- WAIT_SOF:
  - vtc_en=1, bridge_resetn=1.
  - sof_seen sets on s_axis_tvalid & s_axis_tuser.
  - On fs_rise with sof_seen=1 -> RUN; the bad-frame count clears.
  - On fs_rise with sof_seen=0, the timeout count increments; reaching SOF_TIMEOUT -> RECOVER.
- RUN:
  - sync_locked=1.
  - uf_flag sets on any cycle with vtc_active_video & ~s_axis_tvalid.
  - On fs_rise:
    - frame_count increments.
    - If uf_flag: underflow_frames increments and bad-frame count increments; otherwise bad-frame count clears.
    - uf_flag clears, except when an underflow occurs in the same cycle, in which case it stays set for the new frame.
  - Bad-frame count reaching MAX_BAD_FRAMES -> RECOVER.
  - A re-asserted tuser in RUN is ignored.
- RECOVER:
  - bridge_resetn=0, vtc_en stays 1.
  - On entry, restart_count increments.
  - After RECOVER_CYCLES cycles -> WAIT_CLK; vtc_en drops in WAIT_CLK.
- Entry housekeeping:
  - All per-state counters and flags clear on every state entry.
  - irq pulses on the first cycle in RUN or RECOVER.
- Counters:
  - Saturate at all-ones and never wrap.
  - clear_counters zeroes them next cycle.
  - If clear_counters coincides with an increment, the clear wins.
- Mid-operation changes:
  - enable deassert in RUN: bridge_resetn=0 and vtc_en=0 on the next cycle.
  - Async reset mid-frame returns everything to IDLE immediately.

Test Plan:
- Bring-up (LOCK_SETTLE=8, VTC_WARMUP=2):
  - Stimulus: enable=1, mmcm_locked=1, SOF before the 3rd fsync.
  - Required: vtc_en rises 8 cycles after WAIT_CLK entry; bridge_resetn rises on the 2nd fs_rise; sync_locked and irq on the next fs_rise; state_o sequence 0,1,2,3,4.
- Lock glitch:
  - Stimulus: mmcm_locked low for 1 cycle at settle count 5.
  - Required: settle counter restarts from 0; no early vtc_en.
- SOF timeout:
  - Stimulus: tvalid=1, tuser=0 throughout.
  - Required: RECOVER after 4 fs_rise in WAIT_SOF; restart_count=1; bridge_resetn low for 64 cycles; then WAIT_CLK.
- Underflow recovery:
  - Stimulus: in RUN, drop tvalid for 1 active cycle in 3 consecutive frames.
  - Required: underflow_frames=3 and RECOVER on the 3rd fs_rise; one clean frame in between resets the bad-frame count and prevents recovery.
- MMCM loss and enable drop:
  - Stimulus: mmcm_locked=0 in RUN.
  - Required: RECOVER next cycle and irq.
  - Stimulus: enable=0 in RECOVER.
  - Required: IDLE; vtc_en=0 and bridge_resetn=0.
- Counter saturation and clear (CNT_WIDTH=4):
  - Stimulus: run 20 frames.
  - Required: frame_count=15.
  - Stimulus: clear_counters coinciding with fs_rise.
  - Required: frame_count=0.
